// File: rtl/tpu_seq_pkg.sv
// tpu_seq_pkg -- shared definitions for the convolution sequencer.
//   data_t           : datapath word type
//   DEF_* localparams: default geometry and datapath latency
//   state_t          : sequencer FSM states
//   in_range()       : true when pos+off lies inside 0..dim-1
package tpu_seq_pkg;

   typedef logic [15:0] data_t;

   localparam int DEF_MATRIX_DIM = 16;
   localparam int DEF_CONV_DIM   = 3;
   localparam int DEF_PIPE_LAT   = 3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_K,
      LOAD_M,
      COMPUTE,
      DRAIN
   } state_t;

   function automatic logic in_range(input int pos, input int off, input int dim);
      return ((pos + off) >= 0) && ((pos + off) < dim);
   endfunction

endpackage

// File: rtl/tpu_seq_mask.sv
// conv_tap_mask -- combinational border mask for one window position.
//   row, col : window centre
//   tap_mask : bit k = tap k (row-major, tap 0 = top-left); 1 when the tap
//              lands inside the matrix, 0 when it must read zero padding
module conv_tap_mask
   import tpu_seq_pkg::*;
#(
   parameter int MATRIX_DIM = DEF_MATRIX_DIM,
   parameter int CONV_DIM   = DEF_CONV_DIM
)(
   input  logic [$clog2(MATRIX_DIM)-1:0]  row,
   input  logic [$clog2(MATRIX_DIM)-1:0]  col,
   output logic [CONV_DIM*CONV_DIM-1:0]   tap_mask
);

   localparam int NT = CONV_DIM * CONV_DIM;

   // Each tap is an independent range check on its fixed (row, col) offset.
   for (genvar k = 0; k < NT; k++) begin : g_tap
      localparam int DR = k / CONV_DIM - CONV_DIM / 2;
      localparam int DC = k % CONV_DIM - CONV_DIM / 2;
      assign tap_mask[k] = in_range(int'(row), DR, MATRIX_DIM) &&
                           in_range(int'(col), DC, MATRIX_DIM);
   end

endmodule

// File: rtl/tpu_seq.sv
// tpu_seq -- load/compute sequencer for a CONV_DIM x CONV_DIM convolution
// over a MATRIX_DIM x MATRIX_DIM matrix.
//   clk, rst                   : clock, async active-high reset
//   insert_kernel/insert_matrix: a word for that store is on the bus
//   ready                      : downstream accepts a new output position
//   kernel_we/addr, matrix_we/addr : store write strobes (combinational)
//   issue, win_row/col, tap_mask   : window start for the datapath
//   done, out_idx              : result strobe, PIPE_LAT cycles after issue
//   busy                       : FSM not idle
//   error                      : sticky protocol violation
module tpu_seq
   import tpu_seq_pkg::*;
#(
   parameter int MATRIX_DIM = DEF_MATRIX_DIM,
   parameter int CONV_DIM   = DEF_CONV_DIM,
   parameter int PIPE_LAT   = DEF_PIPE_LAT
)(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   insert_kernel,
   input  logic                                   insert_matrix,
   input  logic                                   ready,
   output logic                                   kernel_we,
   output logic [$clog2(CONV_DIM*CONV_DIM)-1:0]   kernel_addr,
   output logic                                   matrix_we,
   output logic [$clog2(MATRIX_DIM*MATRIX_DIM)-1:0] matrix_addr,
   output logic                                   issue,
   output logic [$clog2(MATRIX_DIM)-1:0]          win_row,
   output logic [$clog2(MATRIX_DIM)-1:0]          win_col,
   output logic [CONV_DIM*CONV_DIM-1:0]           tap_mask,
   output logic                                   done,
   output logic [$clog2(MATRIX_DIM*MATRIX_DIM)-1:0] out_idx,
   output logic                                   busy,
   output logic                                   error
);

   localparam int KLEN = CONV_DIM * CONV_DIM;
   localparam int MLEN = MATRIX_DIM * MATRIX_DIM;
   localparam int KAW  = $clog2(KLEN);
   localparam int MAW  = $clog2(MLEN);
   localparam int PW   = $clog2(MATRIX_DIM);
   localparam int KCW  = $clog2(KLEN + 1);
   localparam int MCW  = $clog2(MLEN + 1);

   localparam logic [KCW-1:0] KLEN_C   = KCW'(KLEN);
   localparam logic [MCW-1:0] MLEN_C   = MCW'(MLEN);
   localparam logic [PW-1:0]  LAST_P   = PW'(MATRIX_DIM - 1);
   localparam logic [MAW-1:0] LAST_IDX = MAW'(MLEN - 1);
   localparam logic [MAW-1:0] MDIM_C   = MAW'(MATRIX_DIM);

   state_t               state;
   logic [KCW-1:0]       kcnt;
   logic [MCW-1:0]       mcnt;
   logic                 kernel_loaded, matrix_loaded;
   logic [PIPE_LAT:1]    vld_pipe;
   logic [PIPE_LAT:1][MAW-1:0] idx_pipe;
   logic [MAW-1:0]       cur_idx;
   logic [KLEN-1:0]      raw_mask;
   logic                 last_pos;

   // The first word of a load arrives on the IDLE cycle that starts the
   // load, so IDLE writes address 0 itself rather than losing that word.
   assign kernel_we   = (state == IDLE   && insert_kernel) ||
                        (state == LOAD_K && insert_kernel && kcnt < KLEN_C);
   assign matrix_we   = (state == IDLE   && insert_matrix && !insert_kernel) ||
                        (state == LOAD_M && insert_matrix && mcnt < MLEN_C);
   assign kernel_addr = kcnt[KAW-1:0];
   assign matrix_addr = mcnt[MAW-1:0];

   assign issue    = (state == COMPUTE) && ready;
   assign busy     = (state != IDLE);
   assign cur_idx  = MAW'(win_row) * MDIM_C + MAW'(win_col);
   assign last_pos = (win_row == LAST_P) && (win_col == LAST_P);
   assign done     = vld_pipe[PIPE_LAT];
   assign out_idx  = idx_pipe[PIPE_LAT];

   conv_tap_mask #(
      .MATRIX_DIM (MATRIX_DIM),
      .CONV_DIM   (CONV_DIM)
   ) u_mask (
      .row      (win_row),
      .col      (win_col),
      .tap_mask (raw_mask)
   );

   // Mask is only meaningful while windows are being issued; zero elsewhere
   // so an idle/reset block drives no stray taps.
   assign tap_mask = (state == COMPUTE) ? raw_mask : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         kcnt          <= '0;
         mcnt          <= '0;
         kernel_loaded <= 1'b0;
         matrix_loaded <= 1'b0;
         error         <= 1'b0;
         win_row       <= '0;
         win_col       <= '0;
         vld_pipe      <= '0;
         idx_pipe      <= '0;
      end else begin
         vld_pipe[1] <= issue;
         idx_pipe[1] <= cur_idx;
         for (int i = 2; i <= PIPE_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
         end

         case (state)
            IDLE: begin
               if (insert_kernel) begin
                  state         <= LOAD_K;
                  kcnt          <= KCW'(1);
                  kernel_loaded <= 1'b0;
               end else if (insert_matrix) begin
                  state         <= LOAD_M;
                  mcnt          <= MCW'(1);
                  matrix_loaded <= 1'b0;
               end else if (kernel_loaded && matrix_loaded) begin
                  state <= COMPUTE;
               end
            end
            LOAD_K: begin
               if (insert_kernel) begin
                  // Excess words (e.g. a trailing hold cycle) are dropped.
                  if (kcnt < KLEN_C) kcnt <= kcnt + 1'b1;
               end else begin
                  if (kcnt == KLEN_C) begin
                     kernel_loaded <= 1'b1;
                  end else begin
                     kernel_loaded <= 1'b0;
                     error         <= 1'b1;
                  end
                  kcnt  <= '0;
                  state <= IDLE;
               end
            end
            LOAD_M: begin
               if (insert_matrix) begin
                  if (mcnt < MLEN_C) mcnt <= mcnt + 1'b1;
               end else begin
                  if (mcnt == MLEN_C) begin
                     matrix_loaded <= 1'b1;
                  end else begin
                     matrix_loaded <= 1'b0;
                     error         <= 1'b1;
                  end
                  mcnt  <= '0;
                  state <= IDLE;
               end
            end
            COMPUTE: begin
               if (insert_kernel || insert_matrix) error <= 1'b1;
               if (ready) begin
                  if (last_pos) begin
                     win_row <= '0;
                     win_col <= '0;
                     state   <= DRAIN;
                  end else if (win_col == LAST_P) begin
                     win_col <= '0;
                     win_row <= win_row + 1'b1;
                  end else begin
                     win_col <= win_col + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (insert_kernel || insert_matrix) error <= 1'b1;
               if (done && out_idx == LAST_IDX) begin
                  state         <= IDLE;
                  matrix_loaded <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
